mips_cpu_multdiv: RTL

Iterative multiply/divide unit producing the HI/LO register pair for the MIPS32 core. The combinational ALU handles single-cycle operations. This block executes MULT, MULTU, DIV and DIVU over multiple cycles and holds HI and LO. It also services MTHI/MTLO writes and sits beside the ALU in the execute stage. The control unit stalls on `busy` and reads `hi`/`lo` for MFHI/MFLO.

---
 rtl/mips_cpu_multdiv_if.sv | 22 ++
 rtl/mips_cpu_multdiv.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mips_cpu_multdiv_if.sv
// Request/result bundle between the execute-stage control and the HI/LO
// multiply/divide unit. The master issues requests and the slave answers.
interface mips_cpu_multdiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_cpu_multdiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair. Operands are
// reduced to magnitudes on accept, 32 shift-add or restoring shift-subtract
// steps run in RUN, and FIX applies signs and writes HI/LO in one cycle.
module mips_cpu_multdiv (
    input  logic clk,
    input  logic reset_n,
    mips_cpu_multdiv_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    state_t      next_state;

    logic [5:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] a_raw;
    logic [31:0] opb;
    logic [63:0] acc;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;

    logic        op_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_shift;
    logic        div_fits;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Operand conditioning: signed ops work on magnitudes, 0x80000000 stays 2^31.
    always_comb begin
        op_signed = ~bus.op[0];
        abs_a     = (op_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        abs_b     = (op_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    end

    // One iteration of each algorithm; acc holds {partial, multiplier} or {remainder, quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, opb};
        mul_next  = acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]};
        div_shift = acc[63:31];
        div_fits  = (div_shift >= {1'b0, opb});
        div_rem   = div_shift[31:0] - opb;
        div_next  = div_fits ? {div_rem, acc[30:0], 1'b1}
                             : {div_shift[31:0], acc[30:0], 1'b0};
    end

    // Sign correction of the finished magnitudes.
    always_comb begin
        prod_fix = neg_res ? (~acc + 64'd1) : acc;
        quot_fix = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
        rem_fix  = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: only mult/div requests leave IDLE; RUN lasts exactly 32 cycles.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start && !bus.op[2]) next_state = RUN;
            RUN:  if (cnt == 6'd31) next_state = FIX;
            FIX:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath, HI/LO and the registered busy/done flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt      <= 6'd0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= 32'd0;
            opb      <= 32'd0;
            acc      <= 64'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            3'd0, 3'd1, 3'd2, 3'd3: begin
                                is_div   <= bus.op[1];
                                neg_res  <= op_signed & (bus.a[31] ^ bus.b[31]);
                                neg_rem  <= op_signed & bus.a[31];
                                div_zero <= (bus.b == 32'd0);
                                a_raw    <= bus.a;
                                cnt      <= 6'd0;
                                busy_q   <= 1'b1;
                                if (bus.op[1]) begin
                                    opb <= abs_b;
                                    acc <= {32'd0, abs_a};
                                end else begin
                                    opb <= abs_a;
                                    acc <= {32'd0, abs_b};
                                end
                            end
                            3'd4: hi_q <= bus.a;
                            3'd5: lo_q <= bus.a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    acc <= is_div ? div_next : mul_next;
                    cnt <= cnt + 6'd1;
                end
                FIX: begin
                    if (is_div) begin
                        if (div_zero) begin
                            hi_q <= a_raw;
                            lo_q <= 32'hFFFF_FFFF;
                        end else begin
                            hi_q <= rem_fix;
                            lo_q <= quot_fix;
                        end
                    end else begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
